// File: rtl/ysyx_220066_div_unit_if.sv
// Divider port bundle: execute-side op offer, flush, and writeback-side result/block.
// Pure wiring, no latency.
// master = execute/writeback side, slave = divider.
interface ysyx_220066_div_unit_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic            in_signed;
  logic            in_rem;
  logic            in_word;
  logic [XLEN-1:0] in_src1;
  logic [XLEN-1:0] in_src2;
  logic [4:0]      in_rd;
  logic [63:0]     in_nxtpc;
  logic            in_error;
  logic            flush;
  logic            div_wen;
  logic [4:0]      div_rd;
  logic [XLEN-1:0] div_data;
  logic [63:0]     div_nxtpc;
  logic            div_error;
  logic            div_block;

  modport master (
    output in_valid, in_signed, in_rem, in_word, in_src1, in_src2,
           in_rd, in_nxtpc, in_error, flush, div_block,
    input  in_ready, div_wen, div_rd, div_data, div_nxtpc, div_error
  );

  modport slave (
    input  in_valid, in_signed, in_rem, in_word, in_src1, in_src2,
           in_rd, in_nxtpc, in_error, flush, div_block,
    output in_ready, div_wen, div_rd, div_data, div_nxtpc, div_error
  );
endinterface

// File: rtl/ysyx_220066_div_unit.sv
// Iterative RV64M divider (DIV/DIVU/REM/REMU and W forms), radix-2 restoring.
// Latency: accept edge to first div_wen cycle = XLEN+2 (W: 34); 2 with DIV_EARLY_OUT_EN on trivial cases.
// Backpressure: one op at a time (in_ready only in IDLE); result held in DONE while div_block=1.
module ysyx_220066_div_unit #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input logic                   clk,
  input logic                   rst_n,
  ysyx_220066_div_unit_if.slave bus
);
  localparam int WLEN = 32;

  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] dq;       // dividend shifts out the top, quotient bits shift in at the bottom
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] b_mag;
  logic            op_rem, op_word, op_div0, neg_q, neg_r, first_done;
  logic [4:0]      op_rd;
  logic [63:0]     op_nxtpc;
  logic            op_error;

  logic            rdy_q, wen_q, error_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] data_q;
  logic [63:0]     nxtpc_q;

  logic [XLEN-1:0] a_ext, b_ext, a_mag_c, b_mag_c, dq_load;
  logic            sa, sb;

  // Narrow W operands to 32 bits, extend, and take magnitudes for unsigned iteration
  always_comb begin
    a_ext = bus.in_src1;
    b_ext = bus.in_src2;
    if (bus.in_word) begin
      a_ext = bus.in_signed ? {{(XLEN-WLEN){bus.in_src1[WLEN-1]}}, bus.in_src1[WLEN-1:0]}
                            : {{(XLEN-WLEN){1'b0}}, bus.in_src1[WLEN-1:0]};
      b_ext = bus.in_signed ? {{(XLEN-WLEN){bus.in_src2[WLEN-1]}}, bus.in_src2[WLEN-1:0]}
                            : {{(XLEN-WLEN){1'b0}}, bus.in_src2[WLEN-1:0]};
    end
    sa      = bus.in_signed & a_ext[XLEN-1];
    sb      = bus.in_signed & b_ext[XLEN-1];
    a_mag_c = sa ? -a_ext : a_ext;
    b_mag_c = sb ? -b_ext : b_ext;
    // W dividends sit in the top half so 32 shifts consume exactly their bits
    dq_load = bus.in_word ? {a_mag_c[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : a_mag_c;
  end

`ifdef DIV_EARLY_OUT_EN
  logic [XLEN-1:0] min_c;
  logic            ovf_c, early_c;

  // Detect ops whose result is known without iterating
  always_comb begin
    min_c   = bus.in_word ? {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}}
                          : {1'b1, {(XLEN-1){1'b0}}};
    ovf_c   = bus.in_signed & (a_ext == min_c) & (&b_ext);
    early_c = (b_ext == '0) | ovf_c | (a_mag_c < b_mag_c);
  end
`endif

  logic [XLEN-1:0] rem_lo, rem_nx;
  logic            ge;

  // One restoring step; a set rem msb means the shifted value exceeds any XLEN-bit divisor
  always_comb begin
    rem_lo = {rem[XLEN-2:0], dq[XLEN-1]};
    ge     = rem[XLEN-1] | (rem_lo >= b_mag);
    rem_nx = ge ? rem_lo - b_mag : rem_lo;
  end

  logic [XLEN-1:0] q_mag, q_val, r_val, res;

  // Apply signs and the divide-by-zero quotient; min/-1 falls out of the magnitude math
  always_comb begin
    q_mag = op_word ? {{(XLEN-WLEN){1'b0}}, dq[WLEN-1:0]} : dq;
    q_val = op_div0 ? '1 : (neg_q ? -q_mag : q_mag);
    r_val = neg_r ? -rem : rem;
    res   = op_rem ? r_val : q_val;
    if (op_word) res = {{(XLEN-WLEN){res[WLEN-1]}}, res[WLEN-1:0]};
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      dq         <= '0;
      rem        <= '0;
      b_mag      <= '0;
      op_rem     <= 1'b0;
      op_word    <= 1'b0;
      op_div0    <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      first_done <= 1'b0;
      op_rd      <= '0;
      op_nxtpc   <= '0;
      op_error   <= 1'b0;
      rdy_q      <= 1'b1;
      wen_q      <= 1'b0;
      rd_q       <= '0;
      data_q     <= '0;
      nxtpc_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && !bus.flush) begin
            op_rem   <= bus.in_rem;
            op_word  <= bus.in_word;
            op_div0  <= (b_ext == '0);
            neg_q    <= sa ^ sb;
            neg_r    <= sa;
            op_rd    <= bus.in_rd;
            op_nxtpc <= bus.in_nxtpc;
            op_error <= bus.in_error;
            b_mag    <= b_mag_c;
            rem      <= '0;
            dq       <= dq_load;
            cnt      <= bus.in_word ? CNT_W'(WLEN) : CNT_W'(XLEN);
            rdy_q    <= 1'b0;
            state    <= ITER;
`ifdef DIV_EARLY_OUT_EN
            if (early_c) begin
              cnt   <= '0;
              state <= FIX;
              if (b_ext == '0) begin
                dq  <= '1;
                rem <= a_mag_c;
              end else if (ovf_c) begin
                dq  <= a_mag_c;
                rem <= '0;
              end else begin
                dq  <= '0;
                rem <= a_mag_c;
              end
            end
`endif
          end
        end
        ITER: begin
          if (bus.flush) begin
            rdy_q <= 1'b1;
            state <= IDLE;
          end else begin
            rem <= rem_nx;
            dq  <= {dq[XLEN-2:0], ge};
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= FIX;
          end
        end
        FIX: begin
          if (bus.flush) begin
            rdy_q <= 1'b1;
            state <= IDLE;
          end else begin
            wen_q      <= 1'b1;
            rd_q       <= op_rd;
            data_q     <= res;
            nxtpc_q    <= op_nxtpc;
            error_q    <= op_error;
            first_done <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          // Writeback samples on the first DONE edge, so that edge never retires
          if (first_done) begin
            first_done <= 1'b0;
          end else if (!bus.div_block) begin
            wen_q <= 1'b0;
            rdy_q <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.div_wen   = wen_q;
  assign bus.div_rd    = rd_q;
  assign bus.div_data  = data_q;
  assign bus.div_nxtpc = nxtpc_q;
  assign bus.div_error = error_q;
endmodule

// File: tb/tb_ysyx_220066_div_unit.sv
// Directed bench for the iterative divider: stimulus pushes expectations, monitor pops and compares.
module tb_ysyx_220066_div_unit;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef DIV_EARLY_OUT_EN
  localparam int LS64 = 2;
  localparam int LS32 = 2;
`else
  localparam int LS64 = 66;
  localparam int LS32 = 34;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  ysyx_220066_div_unit_if #(.XLEN(64)) bus ();

  ysyx_220066_div_unit #(.XLEN(64), .CNT_W(7)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
    logic [63:0] pc;
    logic        err;
    int          lat;
    int          hold;
    int          acc;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop on each div_wen rising cycle, then track stability and pulse length
  initial begin : monitor
    logic prev_wen;
    logic in_pulse;
    logic unstable;
    int   len;
    exp_t cur;
    prev_wen = 1'b0;
    in_pulse = 1'b0;
    unstable = 1'b0;
    len      = 0;
    forever begin
      @(negedge clk);
      if (bus.div_wen && !prev_wen) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wen: got div_wen=1 with no op outstanding at cycle %0d", cyc);
          in_pulse = 1'b0;
        end else begin
          cur      = sb_q.pop_front();
          in_pulse = 1'b1;
          unstable = 1'b0;
          len      = 1;
          chk("data", bus.div_data, cur.data);
          chk("rd", 64'(bus.div_rd), 64'(cur.rd));
          chk("nxtpc", bus.div_nxtpc, cur.pc);
          chk("error", 64'(bus.div_error), 64'(cur.err));
          chk("latency", 64'(cyc - cur.acc + 1), 64'(cur.lat));
        end
      end else if (bus.div_wen && in_pulse) begin
        len++;
        if (bus.div_data !== cur.data || bus.div_rd !== cur.rd ||
            bus.div_nxtpc !== cur.pc || bus.div_error !== cur.err)
          unstable = 1'b1;
      end else if (!bus.div_wen && prev_wen && in_pulse) begin
        chk("wen_cycles", 64'(len), 64'(cur.hold));
        chk("stable", 64'(unstable), 64'd0);
        in_pulse = 1'b0;
      end
      prev_wen = bus.div_wen;
    end
  end

  task automatic wait_ready();
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got in_ready=0 after 300 cycles expected 1");
    end
  endtask

  // Offer one op and hold it for exactly its accept edge; returns the accept cycle
  task automatic start_op(input logic sgn, input logic rm, input logic wd,
                          input logic [63:0] s1, input logic [63:0] s2,
                          input logic [4:0] rd, output int acc);
    wait_ready();
    bus.in_valid  = 1'b1;
    bus.in_signed = sgn;
    bus.in_rem    = rm;
    bus.in_word   = wd;
    bus.in_src1   = s1;
    bus.in_src2   = s2;
    bus.in_rd     = rd;
    bus.in_nxtpc  = 64'h0000_0000_8000_0000 + 64'(rd) * 4;
    bus.in_error  = rd[0];
    @(posedge clk);
    #1;
    acc = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic issue(input logic sgn, input logic rm, input logic wd,
                       input logic [63:0] s1, input logic [63:0] s2, input logic [4:0] rd,
                       input logic [63:0] exp, input int lat, input int blk, input logic fl_done);
    exp_t e;
    int   acc;
    bit   hit;
    start_op(sgn, rm, wd, s1, s2, rd, acc);
    e.data = exp;
    e.rd   = rd;
    e.pc   = 64'h0000_0000_8000_0000 + 64'(rd) * 4;
    e.err  = rd[0];
    e.lat  = lat;
    e.hold = blk + 2;
    e.acc  = acc;
    sb_q.push_back(e);
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.div_wen) begin
        hit = 1;
        break;
      end
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL wen_timeout: rd=%0d got no div_wen in 200 cycles expected a result", rd);
      return;
    end
    // Now in DONE cycle 1; block the following blk cycles
    for (int i = 1; i <= blk + 1; i++) begin
      bus.div_block = (i >= 2);
      bus.flush     = fl_done;
      @(negedge clk);
    end
    bus.div_block = 1'b0;
    bus.flush     = 1'b0;
  endtask

  initial begin : stim
    int acc;
    bus.in_valid  = 1'b0;
    bus.in_signed = 1'b0;
    bus.in_rem    = 1'b0;
    bus.in_word   = 1'b0;
    bus.in_src1   = '0;
    bus.in_src2   = '0;
    bus.in_rd     = '0;
    bus.in_nxtpc  = '0;
    bus.in_error  = 1'b0;
    bus.flush     = 1'b0;
    bus.div_block = 1'b0;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_wen", 64'(bus.div_wen), 64'd0);
    chk("rst_rd", 64'(bus.div_rd), 64'd0);
    chk("rst_data", bus.div_data, 64'd0);
    chk("rst_nxtpc", bus.div_nxtpc, 64'd0);
    chk("rst_error", 64'(bus.div_error), 64'd0);
    rst_n = 1'b1;

    //     sgn rem word src1                    src2                    rd  expected                lat   blk fl
    issue(1, 0, 0, 64'd100,                 64'd7,                  5,  64'd14,                 66,   0, 0);
    issue(1, 1, 1, 64'hFFFFFFFF_FFFFFFF9,   64'd2,                  6,  ONES,                   34,   0, 0);
    issue(0, 0, 0, 64'd123,                 64'd0,                  7,  ONES,                   LS64, 0, 0);
    issue(1, 1, 0, 64'd123,                 64'd0,                  8,  64'd123,                LS64, 0, 0);
    issue(1, 0, 0, MIN64,                   ONES,                   9,  MIN64,                  LS64, 0, 0);
    issue(1, 1, 0, MIN64,                   ONES,                   10, 64'd0,                  LS64, 0, 0);
    issue(1, 0, 0, 64'hFFFFFFFF_FFFFFF9C,   64'd7,                  11, 64'hFFFFFFFF_FFFFFFF2,  66,   3, 1);
    issue(1, 1, 0, 64'hFFFFFFFF_FFFFFF9C,   64'd7,                  12, 64'hFFFFFFFF_FFFFFFFE,  66,   1, 0);
    issue(1, 0, 1, 64'h12345678_80000000,   64'h00000000_FFFFFFFF,  13, 64'hFFFFFFFF_80000000,  LS32, 0, 0);
    issue(1, 1, 1, 64'h12345678_80000000,   64'h00000000_FFFFFFFF,  14, 64'd0,                  LS32, 0, 0);
    issue(0, 0, 1, 64'hABCD0000_FFFFFFFF,   64'd2,                  15, 64'h00000000_7FFFFFFF,  34,   0, 0);
    issue(0, 0, 0, 64'd5,                   64'd10,                 16, 64'd0,                  LS64, 0, 0);
    issue(0, 1, 0, 64'd5,                   64'd10,                 17, 64'd5,                  LS64, 0, 0);
    issue(1, 0, 1, 64'd7,                   64'd0,                  18, ONES,                   LS32, 0, 0);
    issue(1, 1, 1, 64'h00000000_FFFFFFFB,   64'd0,                  19, 64'hFFFFFFFF_FFFFFFFB,  LS32, 0, 0);
    issue(0, 0, 0, ONES,                    64'd10,                 20, 64'h19999999_99999999,  66,   0, 0);
    issue(0, 1, 0, ONES,                    64'd10,                 21, 64'd5,                  66,   0, 0);

    // Flush in ITER: op dropped, unit idle the next cycle
    start_op(1, 0, 0, 64'd1000, 64'd3, 22, acc);
    repeat (10) @(negedge clk);
    chk("iter_busy", 64'(bus.in_ready), 64'd0);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_ready", 64'(bus.in_ready), 64'd1);
    chk("flush_wen", 64'(bus.div_wen), 64'd0);
    repeat (80) @(negedge clk);

    // flush together with in_valid in IDLE is not an accept
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    @(negedge clk);
    chk("flush_no_accept", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    repeat (5) @(negedge clk);

    // Asynchronous reset mid-ITER clears held outputs and drops the op
    start_op(0, 0, 0, 64'd999, 64'd4, 23, acc);
    repeat (20) @(negedge clk);
    chk("pre_rst_data", bus.div_data, 64'd5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(bus.in_ready), 64'd1);
    chk("mid_rst_wen", 64'(bus.div_wen), 64'd0);
    chk("mid_rst_rd", 64'(bus.div_rd), 64'd0);
    chk("mid_rst_data", bus.div_data, 64'd0);
    chk("mid_rst_nxtpc", bus.div_nxtpc, 64'd0);
    chk("mid_rst_error", 64'(bus.div_error), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);

    issue(0, 1, 0, 64'd100, 64'd7, 24, 64'd2, 66, 0, 0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
